// File: rtl/hiscore_upload_pkg.sv
// Shared definitions for the hiscore upload/restore block: FSM states,
// default download index and the pending-strobe record.
package hiscore_upload_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    OWN  = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    WR   = 3'd5,
    REL  = 3'd6
  } state_e;

  localparam logic [7:0] HS_INDEX = 8'd4;

  // One strobe captured while waiting for the CPU to release the RAM port.
  typedef struct packed {
    logic        valid;
    logic        is_rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } pend_t;

  function automatic logic holds_port(input state_e s);
    return (s == REQ) || (s == OWN) || (s == RD_A) || (s == RD_D) || (s == WR);
  endfunction

endpackage

// File: rtl/hiscore_upload.sv
// Bridges HPS ioctl upload/download strobes onto the second port of the core
// RAM, pausing the CPU for the duration of the session.
module hiscore_upload
  import hiscore_upload_pkg::*;
#(
  parameter logic [7:0] INDEX    = HS_INDEX,
  parameter int         AW       = 10,
  parameter int         RAM_SIZE = 1024
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ioctl_upload,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic [15:0]   ioctl_addr,
  input  logic          ioctl_rd,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output state_e        dbg_state
);

  localparam logic [16:0] RAM_LIMIT = 17'(RAM_SIZE);

  // Handshake: ioctl_rd/ioctl_wr are single-cycle strobes; the HPS must not
  // issue another strobe while ioctl_wait is high. A strobe that arrives
  // while the port is still being requested is parked in one pending slot.

  state_e        state_q, state_d;
  pend_t         pend_q, pend_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, ram_we_d;
  logic          pause_req_q, pause_req_d;
  logic [7:0]    din_q, din_d;
  logic          oob_q, oob_d;

  logic          session;
  logic          cmd_rd, cmd_wr, cmd_oob;
  logic [15:0]   cmd_addr;
  logic [7:0]    cmd_data;

  always_comb begin
    session = ioctl_upload | (ioctl_download & (ioctl_index == INDEX));
  end

  // A parked strobe takes precedence over anything live on the bus.
  always_comb begin
    if (pend_q.valid) begin
      cmd_rd   = pend_q.is_rd;
      cmd_wr   = ~pend_q.is_rd;
      cmd_addr = pend_q.addr;
      cmd_data = pend_q.data;
    end else begin
      cmd_rd   = ioctl_rd;
      cmd_wr   = ioctl_wr & ~ioctl_rd;
      cmd_addr = ioctl_addr;
      cmd_data = ioctl_dout;
    end
    cmd_oob = ({1'b0, cmd_addr} >= RAM_LIMIT);
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    din_d       = din_q;
    oob_d       = oob_q;

    case (state_q)
      IDLE: begin
        pend_d = '0;
        if (session) state_d = REQ;
      end
      REQ: begin
        if (!pend_q.valid && (ioctl_rd || ioctl_wr)) begin
          pend_d.valid = 1'b1;
          pend_d.is_rd = ioctl_rd;
          pend_d.addr  = ioctl_addr;
          pend_d.data  = ioctl_dout;
        end
        if (pause_ack) state_d = OWN;
      end
      OWN: begin
        if (cmd_rd) begin
          state_d    = RD_A;
          ram_addr_d = cmd_addr[AW-1:0];
          oob_d      = cmd_oob;
          pend_d     = '0;
        end else if (cmd_wr) begin
          state_d     = WR;
          ram_addr_d  = cmd_addr[AW-1:0];
          ram_wdata_d = cmd_data;
          ram_we_d    = ~cmd_oob;
          pend_d      = '0;
        end
      end
      RD_A: state_d = RD_D;
      RD_D: begin
        din_d   = oob_q ? 8'h00 : ram_rdata;
        state_d = OWN;
      end
      WR: state_d = OWN;
      REL: begin
        pend_d = '0;
        if (!pause_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Losing the session abandons whatever is in flight, including reads.
    if (!session && (state_q != IDLE) && (state_q != REL)) begin
      state_d  = REL;
      pend_d   = '0;
      ram_we_d = 1'b0;
      din_d    = din_q;
    end

    pause_req_d = holds_port(state_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      pause_req_q <= 1'b0;
      din_q       <= 8'h00;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      pause_req_q <= pause_req_d;
      din_q       <= din_d;
      oob_q       <= oob_d;
    end
  end

  assign ioctl_wait = (ioctl_rd & session) |
                      (state_q == REQ) | (state_q == RD_A) | (state_q == RD_D);
  assign ioctl_din  = din_q;
  assign pause_req  = pause_req_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign dbg_state  = state_q;

endmodule
